alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the combinational ALU en/a/b/sel/ack port: screens commands,
// drives the ALU through settle and ack wait, and returns result plus status.
module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [1:0]       rsp_err,
  output logic             alu_en,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_sel,
  input  logic [63:0]      alu_out,
  input  logic             alu_ack,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT_ACK, RESP} state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [3:0] SEL_MAX = 4'b1100;
  localparam logic [3:0] SEL_DIV = 4'b0011;
  localparam logic [3:0] SEL_MOD = 4'b0100;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD  = SW'(SETTLE_CYCLES - 1);
  // Loading the full count gives TIMEOUT_CYCLES+1 ack samples, the last at zero.
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [63:0]      rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic             alu_en_q, alu_en_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    alu_en_d     = alu_en_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    op_count_d   = op_count_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          alu_sel_d = cmd_sel;
          if (cmd_sel > SEL_MAX) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 64'd0;
            rsp_err_d   = ERR_ILLEGAL;
          end else if ((cmd_sel == SEL_DIV || cmd_sel == SEL_MOD) && cmd_b == 32'd0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 64'd0;
            rsp_err_d   = ERR_DIV0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        alu_en_d     = 1'b1;
        settle_cnt_d = SETTLE_LOAD;
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          tmo_cnt_d = TIMEOUT_LOAD;
          state_d   = WAIT_ACK;
        end else begin
          settle_cnt_d = settle_cnt_q - SW'(1);
        end
      end
      WAIT_ACK: begin
        if (alu_ack) begin
          rsp_data_d  = alu_out;
          rsp_err_d   = ERR_OK;
          rsp_valid_d = 1'b1;
          alu_en_d    = 1'b0;
          state_d     = RESP;
        end else if (tmo_cnt_q == '0) begin
          rsp_data_d  = 64'd0;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_valid_d = 1'b1;
          alu_en_d    = 1'b0;
          state_d     = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q - TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if (rsp_err_q == ERR_OK) op_count_d = op_count_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered ready: high exactly while the next state is IDLE.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 64'd0;
      rsp_err_q    <= ERR_OK;
      alu_en_q     <= 1'b0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_sel_q    <= 4'd0;
      op_count_q   <= '0;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      alu_en_q     <= alu_en_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      op_count_q   <= op_count_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_en    = alu_en_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: ALU behavioural model, latency,
// screening, timeout, back-pressure and mid-operation reset.
module tb_alu_cmd_sequencer;

  localparam int S = 2;
  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        alu_en;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [63:0] alu_out;
  logic        alu_ack;
  logic [15:0] op_count;

  logic        ack_level = 1'b1;
  int          en_cycles = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  alu_cmd_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_ack(alu_ack), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: only the opcodes exercised here need to be exact.
  always_comb begin
    case (alu_sel)
      4'b0000: alu_out = {32'd0, alu_a} + {32'd0, alu_b};
      4'b0001: alu_out = {32'd0, alu_a} - {32'd0, alu_b};
      4'b0010: alu_out = {32'd0, alu_a} * {32'd0, alu_b};
      4'b0101: alu_out = {32'd0, alu_a & alu_b};
      default: alu_out = {32'd0, alu_a | alu_b};
    endcase
  end
  assign alu_ack = ack_level;

  always @(posedge clk) if (alu_en) en_cycles <= en_cycles + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    int n;
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept_in_time", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // lat = number of clock edges after the acceptance edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Assumes rsp_ready is high; completes the handshake and checks the return to idle.
  task automatic finish_rsp(input string tag);
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int en0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_alu_en", 64'(alu_en), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_sel", 64'(alu_sel), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // ADD 0x94 + 0x61, ack tied high
    en0 = en_cycles;
    send_cmd(32'h94, 32'h61, 4'b0000);
    check("add_ready_low", 64'(cmd_ready), 64'd0);
    wait_rsp(lat);
    check("add_latency", 64'(lat), 64'(S + 2));
    check("add_data", rsp_data, 64'h0000_0000_0000_00F5);
    check("add_err", 64'(rsp_err), 64'd0);
    finish_rsp("add");
    check("add_en_cycles", 64'(en_cycles - en0), 64'(S + 1));
    check("add_op_count", 64'(op_count), 64'd1);

    // MUL 0xFFFFFFFF * 2
    send_cmd(32'hFFFF_FFFF, 32'd2, 4'b0010);
    wait_rsp(lat);
    check("mul_latency", 64'(lat), 64'(S + 2));
    check("mul_data", rsp_data, 64'h0000_0001_FFFF_FFFE);
    check("mul_err", 64'(rsp_err), 64'd0);
    finish_rsp("mul");
    check("mul_op_count", 64'(op_count), 64'd2);

    // Divide by zero is screened
    en0 = en_cycles;
    send_cmd(32'd10, 32'd0, 4'b0011);
    wait_rsp(lat);
    check("div0_valid", 64'(rsp_valid), 64'd1);
    check("div0_err", 64'(rsp_err), 64'b01);
    check("div0_data", rsp_data, 64'd0);
    finish_rsp("div0");

    // Illegal opcode is screened
    send_cmd(32'd5, 32'd6, 4'b1101);
    wait_rsp(lat);
    check("ill_valid", 64'(rsp_valid), 64'd1);
    check("ill_err", 64'(rsp_err), 64'b10);
    check("ill_data", rsp_data, 64'd0);
    finish_rsp("ill");
    check("screen_no_alu_en", 64'(en_cycles - en0), 64'd0);
    check("screen_op_count", 64'(op_count), 64'd2);

    // Ack never arrives
    ack_level = 1'b0;
    send_cmd(32'd3, 32'd4, 4'b0000);
    wait_rsp(lat);
    check("tmo_latency", 64'(lat), 64'(S + T + 2));
    check("tmo_err", 64'(rsp_err), 64'b11);
    check("tmo_data", rsp_data, 64'd0);
    check("tmo_alu_en_off", 64'(alu_en), 64'd0);
    finish_rsp("tmo");
    check("tmo_op_count", 64'(op_count), 64'd2);
    ack_level = 1'b1;

    // Back-pressure: response held, competing command waits
    rsp_ready = 1'b0;
    send_cmd(32'h1234, 32'h10, 4'b0010);
    wait_rsp(lat);
    check("bp_latency", 64'(lat), 64'(S + 2));
    cmd_a = 32'd7; cmd_b = 32'd8; cmd_sel = 4'b0000; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(rsp_valid), 64'd1);
      check("bp_data_stable", rsp_data, 64'h1_2340);
      check("bp_err_stable", 64'(rsp_err), 64'd0);
      check("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", 64'(rsp_valid), 64'd0);
    check("bp_ready_back", 64'(cmd_ready), 64'd1);
    check("bp_op_count", 64'(op_count), 64'd3);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check("held_cmd_latency", 64'(lat), 64'(S + 2));
    check("held_cmd_data", rsp_data, 64'd15);
    finish_rsp("held");
    check("held_op_count", 64'(op_count), 64'd4);

    // Reset during SETTLE
    send_cmd(32'd1, 32'd1, 4'b0000);
    @(negedge clk);
    check("pre_rst_alu_en", 64'(alu_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_alu_en_drop", 64'(alu_en), 64'd0);
    check("async_op_count", 64'(op_count), 64'd0);
    check("async_cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    check("post_rst_ready", 64'(cmd_ready), 64'd1);

    // Fresh AND after reset
    send_cmd(32'hF0, 32'h3C, 4'b0101);
    wait_rsp(lat);
    check("and_latency", 64'(lat), 64'(S + 2));
    check("and_data", rsp_data, 64'h30);
    check("and_err", 64'(rsp_err), 64'd0);
    finish_rsp("and");
    check("and_op_count", 64'(op_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
